cr_huf_comp_sim_sa: RTL and testbench
=====================================

# cr_huf_comp_sim_sa

Size-arbitration stage on the consumer side of the simulated-size handshake in the Huffman compressor. Waits for a block's simulated Huffman size to be ready, captures it with the block's raw byte count, and decides whether the block is emitted Huffman-coded or stored raw. Offers that decision downstream over a valid/ready interface, then returns a one-cycle `sa_st_read_done` to release the producer for the next block.

## Interface
Parameters:
- `SIZE_WIDTH`, 20: width of the simulated size in bits.
- `RAW_WIDTH`, 17: width of the raw byte count.
- `HDR_BITS`, 96: fixed Huffman header overhead in bits, added to the simulated size before comparison.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `st_sa_size_rdy`  in  1  simulated size valid; held high until one cycle after `sa_st_read_done`.
- `st_sa_size_seq_id`  in  `CREOLE_HC_SEQID_WIDTH`  sequence id of the ready block.
- `st_sa_eob`  in  e_pipe_eob  end-of-block type of the ready block.
- `hw_lut_sim_size`  in  SIZE_WIDTH  accumulated simulated size, stable while `st_sa_size_rdy` is high.
- `sa_raw_vld`  in  1  one-cycle strobe qualifying `sa_raw_bytes`.
- `sa_raw_bytes`  in  RAW_WIDTH  raw byte count of the current block.
- `sa_st_read_done`  out  1  one-cycle release pulse to the producer.
- `sa_dec_vld`  out  1  decision valid.
- `sa_dec_rdy`  in  1  downstream accepts the decision.
- `sa_dec_use_huf`  out  1  1 = emit Huffman, 0 = store raw.
- `sa_dec_seq_id`  out  `CREOLE_HC_SEQID_WIDTH`  captured sequence id.
- `sa_dec_eob`  out  e_pipe_eob  captured eob.
- `sa_dec_sim_size`  out  SIZE_WIDTH  captured simulated size.
- `sa_raw_ovr`  out  1  one-cycle pulse when a second raw count arrives before the first is consumed.

## Operation
- FSM states: IDLE, CAPT, CMP, OFFER, REL, WAIT_LOW.
- Raw latch: `sa_raw_vld` while the latch is empty loads `sa_raw_bytes` and sets `raw_full`. `sa_raw_vld` while `raw_full` is set pulses `sa_raw_ovr`; the new value is dropped.
- IDLE: when `st_sa_size_rdy & raw_full`, go to CAPT. If `st_sa_size_rdy` is high without `raw_full`, stay in IDLE.
- CAPT: register `hw_lut_sim_size`, `st_sa_size_seq_id`, `st_sa_eob`; go to CMP.
- CMP: compute `use_huf = ({1'b0,sim} + HDR_BITS) < ({raw_bytes,3'b000})`.
  - Unsigned compare at width max(SIZE_WIDTH+1, RAW_WIDTH+3); no truncation.
  - Ties select raw (`use_huf=0`).
  - raw_bytes == 0 forces `use_huf=0`.
  - Register the result and go to OFFER.
- OFFER: `sa_dec_vld=1` with all `sa_dec_*` fields stable. On `sa_dec_vld & sa_dec_rdy`, clear `raw_full` and go to REL.
- REL: `sa_st_read_done=1` for exactly this cycle; go to WAIT_LOW.
- WAIT_LOW: stay until `st_sa_size_rdy==0`, then go to IDLE. This prevents re-capturing a stale ready.
- Simultaneous `sa_raw_vld` and the OFFER handshake: the new count is loaded and `raw_full` stays set. The new count belongs to the next block; no overflow is flagged.
- `st_sa_eob==MIDDLE` while ready is high is passed through unchanged; no check is made.

## Timing
- Reset values: all outputs 0; `sa_dec_eob` = MIDDLE; FSM = IDLE; `raw_full` = 0; captured registers 0.
- Reset asserted mid-block: everything returns to the reset values on the next edge. `sa_st_read_done` is not issued for the abandoned block.
- Latency, ready (with raw latched) to `sa_dec_vld`: ready sampled high in IDLE at cycle N; CAPT at N+1, CMP at N+2, `sa_dec_vld` high at N+3.
- Latency, handshake to release: handshake at cycle M; `sa_st_read_done` high at M+1 only.
- The producer drops `st_sa_size_rdy` at M+2, so the earliest IDLE is M+3.
- Minimum block-to-block period with `sa_dec_rdy` tied high: 6 cycles.
- `sa_dec_*` fields hold from entry into OFFER until the handshake, regardless of input changes.
- `sa_raw_ovr` is registered: it goes high the cycle after the offending strobe.

## Configuration
- Macro `CR_HUF_COMP_SIM_SA_STATS_EN`, when defined:
  - Adds outputs `sa_stat_huf_cnt[15:0]` and `sa_stat_raw_cnt[15:0]`.
  - Each increments on an OFFER handshake according to `sa_dec_use_huf`.
  - Each saturates at 16'hFFFF and resets to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- raw=100 bytes (800 bits), sim=600: ready at N -> `sa_dec_vld` at N+3, `use_huf=1`, `sa_dec_sim_size`=600; `sa_dec_rdy` high -> `sa_st_read_done` exactly at N+4.
- Tie: sim=704, raw=100 (704+96=800) -> `use_huf=0`. sim=703 -> `use_huf=1`.
- Ready asserted with no raw count; raw strobe 5 cycles later -> `sa_dec_vld` asserted 4 cycles after the strobe; no early decision.
- `sa_dec_rdy` held low 10 cycles while `hw_lut_sim_size` and seq_id change -> outputs stay at the captured values; one `sa_st_read_done` after rdy rises. A second raw strobe during the hold -> one `sa_raw_ovr` pulse and the first count is kept.
- Reset in OFFER -> next cycle `sa_dec_vld=0`, no `sa_st_read_done`. A fresh block then completes normally.
- STATS_EN: 3 Huffman and 2 raw blocks -> counters read 3 and 2. Counter preloaded at FFFF via force stays at FFFF.

Source files
------------

// File: rtl/cr_huf_comp_sim_sa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cr_huf_comp_sim_sa                                         |
// | Description : Size-arbitration stage for the simulated-size handshake.   |
// |               Latches the raw byte count, captures the simulated Huffman |
// |               size and decides Huffman vs. raw. The decision is offered  |
// |               over valid/ready, then the producer is released with a     |
// |               one-cycle read-done pulse.                                 |
// | Options     : CR_HUF_COMP_SIM_SA_STATS_EN adds saturating 16-bit         |
// |               counters of Huffman and raw decisions.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

package cr_huf_comp_sim_sa_pkg;
    typedef enum logic [1:0] {
        MIDDLE       = 2'd0,
        END_OF_BLOCK = 2'd1,
        END_OF_FRAME = 2'd2,
        EOB_RSVD     = 2'd3
    } e_pipe_eob;
endpackage

module cr_huf_comp_sim_sa #(
    parameter int SIZE_WIDTH = 20,
    parameter int RAW_WIDTH  = 17,
    parameter int HDR_BITS   = 96
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  st_sa_size_rdy,
    input  logic [`CREOLE_HC_SEQID_WIDTH-1:0]     st_sa_size_seq_id,
    input  cr_huf_comp_sim_sa_pkg::e_pipe_eob     st_sa_eob,
    input  logic [SIZE_WIDTH-1:0]                 hw_lut_sim_size,
    input  logic                                  sa_raw_vld,
    input  logic [RAW_WIDTH-1:0]                  sa_raw_bytes,
    output logic                                  sa_st_read_done,
    output logic                                  sa_dec_vld,
    input  logic                                  sa_dec_rdy,
    output logic                                  sa_dec_use_huf,
    output logic [`CREOLE_HC_SEQID_WIDTH-1:0]     sa_dec_seq_id,
    output cr_huf_comp_sim_sa_pkg::e_pipe_eob     sa_dec_eob,
    output logic [SIZE_WIDTH-1:0]                 sa_dec_sim_size,
    output logic                                  sa_raw_ovr
`ifdef CR_HUF_COMP_SIM_SA_STATS_EN
    ,
    output logic [15:0]                           sa_stat_huf_cnt,
    output logic [15:0]                           sa_stat_raw_cnt
`endif
);
    import cr_huf_comp_sim_sa_pkg::*;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_CAPT     = 3'd1;
    localparam logic [2:0] c_ST_CMP      = 3'd2;
    localparam logic [2:0] c_ST_OFFER    = 3'd3;
    localparam logic [2:0] c_ST_REL      = 3'd4;
    localparam logic [2:0] c_ST_WAIT_LOW = 3'd5;

    // One extra bit above the wider operand keeps sim + header from wrapping.
    localparam int c_CMP_W = (((SIZE_WIDTH + 1) > (RAW_WIDTH + 3)) ?
                              (SIZE_WIDTH + 1) : (RAW_WIDTH + 3)) + 1;

    logic [2:0]                          r_state;
    logic [2:0]                          w_state_nxt;
    logic                                r_raw_full;
    logic [RAW_WIDTH-1:0]                r_raw_bytes;
    logic                                r_raw_ovr;
    logic [SIZE_WIDTH-1:0]               r_sim;
    logic [`CREOLE_HC_SEQID_WIDTH-1:0]   r_seq_id;
    e_pipe_eob                           r_eob;
    logic                                r_use_huf;
    logic                                w_hs;
    logic [c_CMP_W-1:0]                  w_lhs;
    logic [c_CMP_W-1:0]                  w_rhs;
    logic                                w_use_huf;

    assign w_hs      = (r_state == c_ST_OFFER) && sa_dec_rdy;
    assign w_lhs     = c_CMP_W'(r_sim) + c_CMP_W'(HDR_BITS);
    assign w_rhs     = c_CMP_W'({r_raw_bytes, 3'b000});
    // Ties and empty blocks fall to raw: strict less-than plus zero guard.
    assign w_use_huf = (r_raw_bytes != '0) && (w_lhs < w_rhs);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode; WAIT_LOW blocks re-capture of a ready still held high.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:     if (st_sa_size_rdy && r_raw_full) w_state_nxt = c_ST_CAPT;
            c_ST_CAPT:     w_state_nxt = c_ST_CMP;
            c_ST_CMP:      w_state_nxt = c_ST_OFFER;
            c_ST_OFFER:    if (sa_dec_rdy) w_state_nxt = c_ST_REL;
            c_ST_REL:      w_state_nxt = c_ST_WAIT_LOW;
            c_ST_WAIT_LOW: if (!st_sa_size_rdy) w_state_nxt = c_ST_IDLE;
            default:       w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        sa_dec_vld      = (r_state == c_ST_OFFER);
        sa_st_read_done = (r_state == c_ST_REL);
    end

    // Raw count latch; a strobe coinciding with the handshake belongs to the next block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_raw_full  <= 1'b0;
            r_raw_bytes <= '0;
            r_raw_ovr   <= 1'b0;
        end else begin
            r_raw_ovr <= 1'b0;
            if (sa_raw_vld && (!r_raw_full || w_hs)) begin
                r_raw_bytes <= sa_raw_bytes;
                r_raw_full  <= 1'b1;
            end else if (sa_raw_vld) begin
                r_raw_ovr <= 1'b1;
            end else if (w_hs) begin
                r_raw_full <= 1'b0;
            end
        end
    end

    // Capture block attributes in CAPT and the decision in CMP; held through OFFER.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sim     <= '0;
            r_seq_id  <= '0;
            r_eob     <= MIDDLE;
            r_use_huf <= 1'b0;
        end else if (r_state == c_ST_CAPT) begin
            r_sim     <= hw_lut_sim_size;
            r_seq_id  <= st_sa_size_seq_id;
            r_eob     <= st_sa_eob;
        end else if (r_state == c_ST_CMP) begin
            r_use_huf <= w_use_huf;
        end
    end

    assign sa_dec_use_huf  = r_use_huf;
    assign sa_dec_seq_id   = r_seq_id;
    assign sa_dec_eob      = r_eob;
    assign sa_dec_sim_size = r_sim;
    assign sa_raw_ovr      = r_raw_ovr;

`ifdef CR_HUF_COMP_SIM_SA_STATS_EN
    logic [15:0] r_huf_cnt;
    logic [15:0] r_raw_cnt;

    // Saturating decision counters, stepped on each accepted decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_huf_cnt <= '0;
            r_raw_cnt <= '0;
        end else if (w_hs) begin
            if (r_use_huf && (r_huf_cnt != 16'hFFFF))  r_huf_cnt <= r_huf_cnt + 16'd1;
            if (!r_use_huf && (r_raw_cnt != 16'hFFFF)) r_raw_cnt <= r_raw_cnt + 16'd1;
        end
    end

    assign sa_stat_huf_cnt = r_huf_cnt;
    assign sa_stat_raw_cnt = r_raw_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cr_huf_comp_sim_sa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cr_huf_comp_sim_sa                                      |
// | Description : Directed and randomized bench for cr_huf_comp_sim_sa.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

module tb_cr_huf_comp_sim_sa;
    import cr_huf_comp_sim_sa_pkg::*;

    localparam int SW = 20;
    localparam int RW = 17;
    localparam int HB = 96;
    localparam int QW = `CREOLE_HC_SEQID_WIDTH;

    logic          clk;
    logic          rst;
    logic          st_sa_size_rdy;
    logic [QW-1:0] st_sa_size_seq_id;
    e_pipe_eob     st_sa_eob;
    logic [SW-1:0] hw_lut_sim_size;
    logic          sa_raw_vld;
    logic [RW-1:0] sa_raw_bytes;
    logic          sa_st_read_done;
    logic          sa_dec_vld;
    logic          sa_dec_rdy;
    logic          sa_dec_use_huf;
    logic [QW-1:0] sa_dec_seq_id;
    e_pipe_eob     sa_dec_eob;
    logic [SW-1:0] sa_dec_sim_size;
    logic          sa_raw_ovr;
`ifdef CR_HUF_COMP_SIM_SA_STATS_EN
    logic [15:0]   sa_stat_huf_cnt;
    logic [15:0]   sa_stat_raw_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_huf  = 0;
    int exp_raw  = 0;

    cr_huf_comp_sim_sa #(.SIZE_WIDTH(SW), .RAW_WIDTH(RW), .HDR_BITS(HB)) dut (
        .clk               (clk),
        .rst               (rst),
        .st_sa_size_rdy    (st_sa_size_rdy),
        .st_sa_size_seq_id (st_sa_size_seq_id),
        .st_sa_eob         (st_sa_eob),
        .hw_lut_sim_size   (hw_lut_sim_size),
        .sa_raw_vld        (sa_raw_vld),
        .sa_raw_bytes      (sa_raw_bytes),
        .sa_st_read_done   (sa_st_read_done),
        .sa_dec_vld        (sa_dec_vld),
        .sa_dec_rdy        (sa_dec_rdy),
        .sa_dec_use_huf    (sa_dec_use_huf),
        .sa_dec_seq_id     (sa_dec_seq_id),
        .sa_dec_eob        (sa_dec_eob),
        .sa_dec_sim_size   (sa_dec_sim_size),
        .sa_raw_ovr        (sa_raw_ovr)
`ifdef CR_HUF_COMP_SIM_SA_STATS_EN
        ,
        .sa_stat_huf_cnt   (sa_stat_huf_cnt),
        .sa_stat_raw_cnt   (sa_stat_raw_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decision: Huffman only if its total bit cost is strictly below raw bits.
    function automatic bit model_huf(input longint unsigned sim, input longint unsigned raw);
        return (raw != 0) && ((sim + HB) < (raw * 8));
    endfunction

    task automatic note_decision(input bit u);
        if (u) exp_huf++;
        else   exp_raw++;
    endtask

    // One full block: optional raw strobe, ready, offer with optional hold, release.
    task automatic run_block(input int unsigned sim, input int unsigned raw,
                             input int unsigned seq, input int unsigned eob,
                             input bit pre_strobe, input int hold, input bit do_ovr,
                             input bit nx_strobe, input int unsigned nx_raw);
        bit exp_u;
        exp_u = model_huf(sim, raw);
        if (pre_strobe) begin
            sa_raw_vld   = 1'b1;
            sa_raw_bytes = RW'(raw);
            tick();
            sa_raw_vld   = 1'b0;
            sa_raw_bytes = RW'($urandom);
        end
        st_sa_size_rdy    = 1'b1;
        hw_lut_sim_size   = SW'(sim);
        st_sa_size_seq_id = QW'(seq);
        st_sa_eob         = e_pipe_eob'(eob[1:0]);
        tick();
        chk("capt_vld", sa_dec_vld, 0);
        tick();
        chk("cmp_vld", sa_dec_vld, 0);
        tick();
        chk("offer_vld", sa_dec_vld, 1);
        chk("offer_use_huf", sa_dec_use_huf, exp_u);
        chk("offer_sim", sa_dec_sim_size, sim);
        chk("offer_seq", sa_dec_seq_id, seq);
        chk("offer_eob", sa_dec_eob, eob[1:0]);
        chk("offer_done", sa_st_read_done, 0);
        for (int i = 0; i < hold; i++) begin
            hw_lut_sim_size   = SW'($urandom);
            st_sa_size_seq_id = QW'($urandom);
            sa_raw_vld        = do_ovr && (i == 2);
            sa_raw_bytes      = RW'($urandom);
            tick();
            sa_raw_vld = 1'b0;
            chk("hold_vld", sa_dec_vld, 1);
            chk("hold_use_huf", sa_dec_use_huf, exp_u);
            chk("hold_sim", sa_dec_sim_size, sim);
            chk("hold_seq", sa_dec_seq_id, seq);
            chk("hold_done", sa_st_read_done, 0);
            chk("hold_ovr", sa_raw_ovr, (do_ovr && (i == 2)) ? 1 : 0);
        end
        sa_dec_rdy = 1'b1;
        if (nx_strobe) begin
            sa_raw_vld   = 1'b1;
            sa_raw_bytes = RW'(nx_raw);
        end
        tick();
        sa_dec_rdy = 1'b0;
        sa_raw_vld = 1'b0;
        note_decision(exp_u);
        chk("rel_done", sa_st_read_done, 1);
        chk("rel_vld", sa_dec_vld, 0);
        chk("rel_ovr", sa_raw_ovr, 0);
        tick();
        chk("wait_done", sa_st_read_done, 0);
        chk("wait_vld", sa_dec_vld, 0);
        st_sa_size_rdy = 1'b0;
        tick();
        chk("idle_done", sa_st_read_done, 0);
        chk("idle_vld", sa_dec_vld, 0);
    endtask

    initial begin
        bit exp_u;
        rst               = 1'b1;
        st_sa_size_rdy    = 1'b0;
        st_sa_size_seq_id = '0;
        st_sa_eob         = MIDDLE;
        hw_lut_sim_size   = '0;
        sa_raw_vld        = 1'b0;
        sa_raw_bytes      = '0;
        sa_dec_rdy        = 1'b0;
        tick();
        tick();
        chk("rst_vld", sa_dec_vld, 0);
        chk("rst_done", sa_st_read_done, 0);
        chk("rst_use_huf", sa_dec_use_huf, 0);
        chk("rst_seq", sa_dec_seq_id, 0);
        chk("rst_eob", sa_dec_eob, MIDDLE);
        chk("rst_sim", sa_dec_sim_size, 0);
        chk("rst_ovr", sa_raw_ovr, 0);
        rst = 1'b0;
        tick();

        // Basic Huffman win, then tie and one-below-tie, then zero-length block.
        run_block(600, 100, 8'h11, 1, 1, 0, 0, 0, 0);
        run_block(704, 100, 8'h22, 2, 1, 0, 0, 0, 0);
        run_block(703, 100, 8'h33, 0, 1, 0, 0, 0, 0);
        run_block(0,   0,   8'h44, 3, 1, 0, 0, 0, 0);

        // Ready without a raw count: no decision until the strobe arrives.
        st_sa_size_rdy    = 1'b1;
        hw_lut_sim_size   = SW'(1000);
        st_sa_size_seq_id = QW'(8'h55);
        st_sa_eob         = END_OF_FRAME;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("noraw_vld", sa_dec_vld, 0);
        end
        sa_raw_vld   = 1'b1;
        sa_raw_bytes = RW'(200);
        tick();
        sa_raw_vld = 1'b0;
        chk("noraw_s1", sa_dec_vld, 0);
        tick();
        chk("noraw_s2", sa_dec_vld, 0);
        tick();
        chk("noraw_s3", sa_dec_vld, 0);
        tick();
        chk("noraw_s4_vld", sa_dec_vld, 1);
        exp_u = model_huf(1000, 200);
        chk("noraw_use_huf", sa_dec_use_huf, exp_u);
        sa_dec_rdy = 1'b1;
        tick();
        sa_dec_rdy = 1'b0;
        note_decision(exp_u);
        chk("noraw_done", sa_st_read_done, 1);
        tick();
        st_sa_size_rdy = 1'b0;
        tick();

        // Long hold with changing inputs and an overflow strobe mid-hold.
        run_block(500, 200, 8'h66, 1, 1, 10, 1, 0, 0);

        // Back-to-back: next count arrives on the handshake, next block needs no strobe.
        run_block(300, 50, 8'h77, 0, 1, 0, 0, 1, 40);
        run_block(200, 40, 8'h78, 1, 0, 0, 0, 0, 0);

        // Reset while offering abandons the block without a release.
        sa_raw_vld   = 1'b1;
        sa_raw_bytes = RW'(90);
        tick();
        sa_raw_vld        = 1'b0;
        st_sa_size_rdy    = 1'b1;
        hw_lut_sim_size   = SW'(123);
        st_sa_size_seq_id = QW'(8'h99);
        st_sa_eob         = END_OF_BLOCK;
        tick();
        tick();
        tick();
        chk("rstoff_vld_pre", sa_dec_vld, 1);
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        st_sa_size_rdy = 1'b0;
        exp_huf        = 0;
        exp_raw        = 0;
        chk("rstoff_vld", sa_dec_vld, 0);
        chk("rstoff_done", sa_st_read_done, 0);
        chk("rstoff_sim", sa_dec_sim_size, 0);
        chk("rstoff_eob", sa_dec_eob, MIDDLE);
        tick();
        chk("rstoff_done2", sa_st_read_done, 0);
        run_block(400, 70, 8'hA0, 2, 1, 1, 0, 0, 0);

        // Randomized blocks: half near the tie point, half fully random.
        for (int i = 0; i < 12; i++) begin
            int unsigned r;
            int          s;
            if (i % 2 == 0) begin
                r = $urandom_range(1, 2000);
                s = int'(r * 8) - HB + int'($urandom_range(0, 8)) - 4;
                if (s < 0) s = int'($urandom_range(0, 50));
            end else begin
                r = $urandom_range(0, (1 << RW) - 1);
                s = int'($urandom_range(0, (1 << SW) - 1));
            end
            run_block(s, r, $urandom_range(0, 255), $urandom_range(0, 3), 1,
                      $urandom_range(0, 3), 0, 0, 0);
        end

`ifdef CR_HUF_COMP_SIM_SA_STATS_EN
        chk("stat_huf", sa_stat_huf_cnt, exp_huf);
        chk("stat_raw", sa_stat_raw_cnt, exp_raw);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
